// File: rtl/uart_tx_device.sv
// uart_tx_device: memory-mapped 8N1 UART transmitter with TX FIFO and LSR.
// Optional console mirror of accepted bytes: define UART_TX_SIM_PRINT_EN.
module uart_tx_device #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        ren,
    output logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [1:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic thr_hit, lsr_hit;
    logic full, empty;
    logic push, drop, pop;
    logic baud_done, temt;
    logic unused_bits;

    assign thr_hit   = wen && (addr[15:0] == 16'h03f8) && wstrb[0];
    assign lsr_hit   = (addr[15:0] == 16'h03fd);
    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    // Full is judged on the pre-pop count, so a push racing a pop into
    // a full FIFO is still dropped.
    assign push      = thr_hit && !full;
    assign drop      = thr_hit && full;
    assign baud_done = (baud_q == BAUD_MAX);
    assign temt      = empty && (state_q == S_IDLE);
    assign tx        = tx_q;

    assign rdata = lsr_hit
        ? {25'b0, temt, ~full, 3'b0, ovf_q, 1'b0}
        : 32'b0;

    assign unused_bits = ^{addr[31:16], wdata[31:8], wstrb[3:1]};

    // Serializer next-state: frame sequencing, FIFO pop and line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping and sticky overflow; a fresh drop beats the clear.
    always_comb begin
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ren && lsr_hit) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers; reset idles the line and discards queued bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_SIM_PRINT_EN
    // FIFO storage write, mirroring each accepted byte to the console.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata[7:0];
            $write("%c", wdata[7:0]);
        end
    end
`else
    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device: scoreboard bench for uart_tx_device.
// A line monitor decodes frames and pops expected bytes from a queue.
module tb_uart_tx_device;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        ren;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic        tx;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int mon_gap = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    uart_tx_device #(
        .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .ren(ren),
        .rdata(rdata),
        .wdata(wdata),
        .wen(wen),
        .wstrb(wstrb),
        .tx(tx)
    );

    task automatic run_monitor();
        int cyc = 0;
        int cnt = 0;
        int end_cyc = -1000;
        int idx;
        bit busy = 0;
        logic [7:0] data = '0;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy = 0;
            end else if (!busy) begin
                if (tx === 1'b0) begin
                    busy = 1;
                    cnt = 0;
                    mon_gap = cyc - end_cyc;
                end
            end else begin
                cnt++;
                idx = cnt / CLK_DIV;
                if (cnt % CLK_DIV == 2) begin
                    if (idx == 0) begin
                        checks++;
                        if (tx !== 1'b0) begin
                            errors++;
                            $display("FAIL start_bit: tx=%b expected 0", tx);
                        end
                    end else if (idx <= 8) begin
                        data[idx-1] = tx;
                    end else begin
                        checks++;
                        if (tx !== 1'b1) begin
                            errors++;
                            $display("FAIL stop_bit: tx=%b expected 1", tx);
                        end
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL frame_unexpected: got %h expected none", data);
                        end else begin
                            exp = sb_q.pop_front();
                            if (data !== exp) begin
                                errors++;
                                $display("FAIL frame_data: got %h expected %h", data, exp);
                            end
                        end
                        frames++;
                    end
                end
                if (cnt == FRAME - 1) begin
                    busy = 0;
                    end_cyc = cyc;
                end
            end
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                             input logic [3:0] s, input bit sb);
        @(negedge clk);
        addr = {16'h0, a};
        wdata = {24'h0, d};
        wstrb = s;
        wen = 1'b1;
        if (sb) sb_q.push_back(d);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
        wstrb = 4'h0;
        addr = 32'h0000_03fd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 1", tx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rdata !== 32'h60) begin
            errors++;
            $display("FAIL reset_lsr: got %h expected 00000060", rdata);
        end
        addr = 32'h0000_03f8;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL thr_read: got %h expected 00000000", rdata);
        end
        addr = 32'h0000_03fd;
    endtask

    task automatic test_single_frame();
        int f0 = frames;
        logic [9:0] bits = {1'b1, 8'h55, 1'b0};
        bus_write(16'h03f8, 8'h55, 4'hf, 1);
        bus_idle();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== bits[i / CLK_DIV]) begin
                errors++;
                $display("FAIL frame55_tx[%0d]: got %b expected %b", i, tx, bits[i / CLK_DIV]);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (rdata !== 32'h60) begin
            errors++;
            $display("FAIL frame55_lsr: got %h expected 00000060", rdata);
        end
        checks++;
        if (frames !== f0 + 1) begin
            errors++;
            $display("FAIL frame55_count: got %0d expected %0d", frames, f0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = frames;
        int bad = 0;
        bus_write(16'h03f8, 8'h48, 4'hf, 1);
        bus_write(16'h03f8, 8'h69, 4'hf, 1);
        bus_idle();
        for (int i = 0; i < 2 * FRAME - 1; i++) begin
            @(negedge clk);
            #1;
            if (rdata[6] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_temt_busy: got %0d cycles high expected 0", bad);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rdata !== 32'h60) begin
            errors++;
            $display("FAIL b2b_lsr_after: got %h expected 00000060", rdata);
        end
        checks++;
        if (frames !== f0 + 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected %0d", frames, f0 + 2);
        end
        checks++;
        if (mon_gap !== 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d expected 1", mon_gap);
        end
    endtask

    task automatic test_overflow();
        int f0 = frames;
        for (int i = 0; i < 6; i++) begin
            bus_write(16'h03f8, 8'(8'h30 + i), 4'hf, i < 5);
        end
        bus_idle();
        #1;
        checks++;
        if (rdata[1] !== 1'b1 || rdata[5] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_lsr: got %h expected bit1=1 bit5=0", rdata);
        end
        @(negedge clk);
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        #1;
        checks++;
        if (rdata[1] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %h expected bit1=0", rdata);
        end
        for (int i = 0; i < 6 * FRAME && !(frames >= f0 + 5 && rdata[6]); i++) begin
            @(negedge clk);
            #1;
        end
        repeat (2 * FRAME) @(negedge clk);
        #1;
        checks++;
        if (frames !== f0 + 5) begin
            errors++;
            $display("FAIL ovf_frames: got %0d expected %0d", frames, f0 + 5);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_pending: got %0d expected 0", sb_q.size());
        end
        checks++;
        if (rdata !== 32'h60) begin
            errors++;
            $display("FAIL ovf_lsr_end: got %h expected 00000060", rdata);
        end
    endtask

    task automatic test_ignored_writes();
        int f0 = frames;
        int lows = 0;
        bus_write(16'h03f8, 8'h58, 4'b1110, 0);
        bus_write(16'h03fc, 8'h59, 4'b1111, 0);
        bus_idle();
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        #1;
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL ignored_tx: got %0d low cycles expected 0", lows);
        end
        checks++;
        if (rdata !== 32'h60) begin
            errors++;
            $display("FAIL ignored_lsr: got %h expected 00000060", rdata);
        end
        checks++;
        if (frames !== f0) begin
            errors++;
            $display("FAIL ignored_frames: got %0d expected %0d", frames, f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int f0 = frames;
        int lows = 0;
        bus_write(16'h03f8, 8'ha5, 4'hf, 0);
        bus_write(16'h03f8, 8'h3c, 4'hf, 0);
        bus_idle();
        repeat (17) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit3: got %b expected 0", tx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_tx: got %b expected 1", tx);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (rdata !== 32'h60) begin
            errors++;
            $display("FAIL mid_reset_lsr: got %h expected 00000060", rdata);
        end
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || frames !== f0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d low cycles %0d frames expected 0 and %0d",
                     lows, frames, f0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr = 32'h0000_03fd;
        wdata = '0;
        wen = 1'b0;
        ren = 1'b0;
        wstrb = 4'h0;
        fork
            run_monitor();
        join_none
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_ignored_writes();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_device.md
# uart_tx_device

Synthesizable memory-mapped UART transmitter on the core's simple data bus, decoding the same 16550-style window (THR at low address 0x03f8). Byte writes from the core are queued in a small FIFO and serialized 8N1 onto a single `tx` pin. A line-status register lets software poll for space and completion. The block replaces the simulation-only console sink on FPGA builds and can mirror characters to the simulator console.

## Interface
- `CLK_DIV`, 16: clock cycles per bit; legal range 2..65535.
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, 2..256.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `addr`  input  32  bus address; only `addr[15:0]` decoded.
- `ren`  input  1  read strobe.
- `rdata`  output  32  read data, combinational from `addr`.
- `wdata`  input  32  write data; `wdata[7:0]` is the character.
- `wen`  input  1  write strobe, one write per asserted cycle.
- `wstrb`  input  4  byte enables; only `wstrb[0]` is used.
- `tx`  output  1  serial line, idle high.

## Operation
- THR push: `wen && addr[15:0]==16'h03f8 && wstrb[0]`. Pushes `wdata[7:0]` if FIFO not full. If full, the byte is dropped and sticky `ovf` is set.
- LSR read at `addr[15:0]==16'h03fd`: `rdata = {25'b0, temt, thre_space, 3'b0, ovf, 1'b0}`.
  - bit1 `ovf`: sticky overflow.
  - bit5: FIFO not full.
  - bit6: FIFO empty and serializer IDLE.
  - All other addresses, including THR, read 0.
- `ovf` clears on the cycle after `ren` at the LSR address. A new overflow in the same cycle as the clearing read leaves `ovf` set.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START: FIFO non-empty; pops the head into the shift register.
  - START -> DATA: after `CLK_DIV` cycles with `tx=0`.
  - DATA -> STOP: after 8 bits, LSB first, `CLK_DIV` cycles each. A 3-bit index counts the bits.
  - STOP -> START: after `CLK_DIV` cycles with `tx=1`, if the FIFO is non-empty (pops immediately, no idle gap).
  - STOP -> IDLE: after `CLK_DIV` cycles with `tx=1`, if the FIFO is empty.
- Baud counter is 16 bits, reloads to 0 on every state entry and counts to `CLK_DIV-1`.
- Simultaneous push and pop:
  - Non-full FIFO: both happen and the count is unchanged.
  - Full FIFO: the full check uses the pre-pop count, so the push is dropped and `ovf` is set.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is one bit wider.
- `tx` is registered, driven from the FSM state and the shift-register LSB.

## Timing
- Reset values:
  - `tx=1`, FSM IDLE, FIFO empty, `ovf=0`, counters 0.
  - `rdata` is combinational: LSR reads `0x60` after reset.
- Reset mid-frame: `tx` returns high asynchronously and queued bytes are discarded.
- Push is visible in LSR the cycle after the write edge.
- Latency from push into an empty idle block to the `tx` falling edge: 2 clock edges (push, then pop/START).
- Frame length is exactly `10*CLK_DIV` cycles. Back-to-back frames are contiguous.
- `temt` rises on the same edge the FSM enters IDLE, which is the end of the stop bit.

## Configuration
- `UART_TX_SIM_PRINT_EN` defined: every accepted push also executes `$fwrite(32'h8000_0001, "%c", wdata[7:0])` at the push edge. Dropped bytes are not printed. This block is non-synthesizable.
- `UART_TX_SIM_PRINT_EN` undefined: no system tasks; the block is fully synthesizable. Serial behaviour is identical in both cases.

## Test plan
Test parameters: `CLK_DIV=4`, `FIFO_DEPTH=4`.
- Reset, then read LSR -> `rdata=0x60`, `tx=1`.
- Write `0x55` to 0x03f8 -> `tx` low 4 cycles starting 2 edges later, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. Total 40 cycles. LSR returns `0x60` afterwards.
- Write "Hi" back-to-back -> two frames in 80 contiguous cycles with no idle gap; bit6 is 0 throughout and 1 after.
- Write 6 bytes on consecutive cycles into an idle block:
  - Byte 1 is popped, 4 are queued, byte 6 is dropped.
  - LSR bit1=1 and bit5=0.
  - An LSR read then clears bit1.
  - Exactly 5 frames are emitted.
- Write with `wstrb=4'b1110`, and write to 0x03fc -> no frame, LSR unchanged.
- Assert `rst_n=0` during DATA bit 3 -> `tx=1` immediately; after release, LSR reads `0x60` and no further frames are emitted.
